keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner for a 4x4 keypad.
// Drives one column low at a time and synchronises the raw rows.
// Debounces both press and release, then emits a single key code per press.
// A one-entry holding register with acknowledge and a sticky overrun flag
// hands the key code to the consumer.
module keypad_scan_ctrl #(
    parameter int SCAN_CYC     = 1000,
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic       clck_i,
    input  logic       rst_n_i,
    input  logic [3:0] filas_i,
    output logic [3:0] columnas_o,
    output logic [3:0] key_o,
    output logic       key_valid_o,
    input  logic       key_ack_i,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CNT_MAX = (SCAN_CYC > DEBOUNCE_CYC) ? SCAN_CYC : DEBOUNCE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYC - 1);
    localparam logic [CW-1:0] DEB_DONE  = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESS    = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    logic [3:0]    sync1_q, sync2_q;
    logic [1:0]    state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    rowIdx_q, rowIdx_d;
    logic [3:0]    rowPat_q, rowPat_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic [3:0]    rows;
    logic          rowsOneHot;
    logic [1:0]    rowEnc;
    logic [CW-1:0] cntInc;

    // Rows are active-low on the pins; invert so 1 means pressed.
    assign rows       = ~sync2_q;
    assign rowsOneHot = (rows != 4'd0) && ((rows & (rows - 4'd1)) == 4'd0);
    assign cntInc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

    assign columnas_o  = ~(4'b0001 << col_q);
    assign key_o       = key_q;
    assign key_valid_o = valid_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != ST_SCAN);

    // Two-flop synchroniser for the asynchronous row inputs; idles at all-released.
    always_ff @(posedge clck_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= filas_i;
            sync2_q <= sync1_q;
        end
    end

    // Encode the index of the single pressed row (only used when one-hot).
    always_comb begin
        rowEnc = 2'd0;
        if (rows[1]) rowEnc = 2'd1;
        if (rows[2]) rowEnc = 2'd2;
        if (rows[3]) rowEnc = 2'd3;
    end

    // Scan/debounce state machine plus the key holding register and overrun logic.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        rowIdx_d = rowIdx_q;
        rowPat_d = rowPat_q;
        key_d    = key_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;

        case (state_q)
            ST_SCAN: begin
                if (cnt_q >= SCAN_LAST) begin
                    cnt_d = '0;
                    if (rowsOneHot) begin
                        rowIdx_d = rowEnc;
                        rowPat_d = rows;
                        state_d  = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cntInc;
                end
            end
            ST_DEBOUNCE: begin
                if (rows != rowPat_q) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_DONE) begin
                    state_d = ST_PRESS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cntInc;
                end
            end
            ST_PRESS: begin
                key_d   = {rowIdx_q, col_q};
                valid_d = 1'b1;
                if (valid_q && !key_ack_i) begin
                    ovr_d = 1'b1;
                end
                state_d = ST_WAIT_REL;
                cnt_d   = '0;
            end
            default: begin
                if (rows != 4'd0) begin
                    cnt_d = '0;
                end else if (cnt_q >= DEB_DONE) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cntInc;
                end
            end
        endcase

        // A new key loading in PRESS takes priority over a plain acknowledge.
        if (state_q != ST_PRESS && valid_q && key_ack_i) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // State, counters and output registers with asynchronous clear.
    always_ff @(posedge clck_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_SCAN;
            col_q    <= 2'd0;
            cnt_q    <= '0;
            rowIdx_q <= 2'd0;
            rowPat_q <= 4'd0;
            key_q    <= 4'd0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            rowIdx_q <= rowIdx_d;
            rowPat_q <= rowPat_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_CYC=4, DEBOUNCE_CYC=8.
// A small keypad model pulls a row low when its pressed key's column is driven.
module tb_keypad_scan_ctrl;

    logic        clock = 1'b0;
    logic        resetN = 1'b1;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic [3:0]  keyCode;
    logic        keyValid;
    logic        keyAck = 1'b0;
    logic        overrun;
    logic        busy;
    logic [15:0] pressed = 16'd0;

    int testsRun = 0;
    int testsFailed = 0;

    keypad_scan_ctrl #(
        .SCAN_CYC(4),
        .DEBOUNCE_CYC(8)
    ) dut (
        .clck_i(clock),
        .rst_n_i(resetN),
        .filas_i(filas),
        .columnas_o(columnas),
        .key_o(keyCode),
        .key_valid_o(keyValid),
        .key_ack_i(keyAck),
        .overrun_o(overrun),
        .busy_o(busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // Keypad matrix: a pressed key at (row, col) pulls its row low while its column is low.
    always_comb begin
        filas = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !columnas[c]) filas[r] = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] keys, input logic ack, input int cycles);
        pressed = keys;
        keyAck  = ack;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitBusy(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < limit) begin
            @(negedge clock);
            n++;
        end
        checkOutput("busy_rise", {7'd0, busy}, 8'd1);
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        checkOutput("busy_fall", {7'd0, busy}, 8'd0);
    endtask

    localparam logic [15:0] KEY_A = 16'h0200;   // row 2, column 1 -> code 1001
    localparam logic [15:0] KEY_B = 16'h0080;   // row 1, column 3 -> code 0111
    localparam logic [15:0] KEY_2ROW = 16'h4004; // rows 0 and 3 on column 2

    // Directed test sequence.
    initial begin
        logic [3:0] one;
        logic [3:0] expCol;
        int n;
        one = 4'b0001;

        // Asynchronous reset with the clock idle.
        #1 resetN = 1'b0;
        #1;
        checkOutput("rst_col", {4'd0, columnas}, 8'h0E);
        checkOutput("rst_key", {4'd0, keyCode}, 8'h00);
        checkOutput("rst_valid", {7'd0, keyValid}, 8'd0);
        checkOutput("rst_ovr", {7'd0, overrun}, 8'd0);
        checkOutput("rst_busy", {7'd0, busy}, 8'd0);
        applyStimulus(16'd0, 1'b0, 3);
        resetN = 1'b1;

        // Idle scanning: each column held four cycles, wrapping after column 3.
        for (int k = 0; k <= 32; k++) begin
            expCol = ~(one << ((k / 4) % 4));
            checkOutput("idle_col", {4'd0, columnas}, {4'd0, expCol});
            checkOutput("idle_valid", {7'd0, keyValid}, 8'd0);
            checkOutput("idle_busy", {7'd0, busy}, 8'd0);
            if (k < 32) applyStimulus(16'd0, 1'b0, 1);
        end

        // Single key: row 2 on column 1, latency measured from DEBOUNCE entry.
        applyStimulus(KEY_A, 1'b0, 0);
        waitBusy(64);
        checkOutput("deb_col", {4'd0, columnas}, 8'h0D);
        n = 0;
        while (keyValid !== 1'b1 && n < 30) begin
            applyStimulus(KEY_A, 1'b0, 1);
            n++;
        end
        checkOutput("press_latency", n[7:0], 8'd10);
        checkOutput("press_key", {4'd0, keyCode}, 8'h09);
        checkOutput("press_ovr", {7'd0, overrun}, 8'd0);
        applyStimulus(KEY_A, 1'b0, 2);
        applyStimulus(KEY_A, 1'b1, 1);
        applyStimulus(KEY_A, 1'b0, 0);
        checkOutput("ack_clears", {7'd0, keyValid}, 8'd0);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(KEY_A, 1'b0, 1);
            checkOutput("held_no_repeat", {7'd0, keyValid}, 8'd0);
            checkOutput("held_busy", {7'd0, busy}, 8'd1);
        end
        applyStimulus(16'd0, 1'b0, 8);
        checkOutput("release_busy", {7'd0, busy}, 8'd1);
        applyStimulus(16'd0, 1'b0, 4);
        checkOutput("release_idle", {7'd0, busy}, 8'd0);
        checkOutput("release_col", {4'd0, columnas}, 8'h0B);

        // Acknowledge with nothing pending is ignored.
        applyStimulus(16'd0, 1'b1, 1);
        applyStimulus(16'd0, 1'b0, 0);
        checkOutput("stray_ack_valid", {7'd0, keyValid}, 8'd0);
        checkOutput("stray_ack_ovr", {7'd0, overrun}, 8'd0);

        // Bouncing key: toggles every three cycles, never stable long enough.
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) pressed = pressed ^ KEY_A;
            applyStimulus(pressed, 1'b0, 1);
            checkOutput("bounce_valid", {7'd0, keyValid}, 8'd0);
        end
        waitIdle(20);

        // Two rows on one column count as no key.
        for (int k = 0; k < 40; k++) begin
            applyStimulus(KEY_2ROW, 1'b0, 1);
            checkOutput("tworow_busy", {7'd0, busy}, 8'd0);
        end
        checkOutput("tworow_valid", {7'd0, keyValid}, 8'd0);
        n = 0;
        while (columnas !== 4'b0111 && n < 20) begin
            applyStimulus(KEY_2ROW, 1'b0, 1);
            n++;
        end
        checkOutput("tworow_advance", {4'd0, columnas}, 8'h07);
        applyStimulus(16'd0, 1'b0, 0);

        // Overrun: second key debounced without acknowledge.
        waitIdle(20);
        applyStimulus(KEY_A, 1'b0, 0);
        waitBusy(64);
        applyStimulus(KEY_A, 1'b0, 10);
        checkOutput("ovr_first_valid", {7'd0, keyValid}, 8'd1);
        checkOutput("ovr_first_key", {4'd0, keyCode}, 8'h09);
        applyStimulus(16'd0, 1'b0, 0);
        waitIdle(30);
        applyStimulus(KEY_B, 1'b0, 0);
        waitBusy(64);
        applyStimulus(KEY_B, 1'b0, 9);
        checkOutput("ovr_before_key", {4'd0, keyCode}, 8'h09);
        checkOutput("ovr_before_flag", {7'd0, overrun}, 8'd0);
        applyStimulus(KEY_B, 1'b0, 1);
        checkOutput("ovr_key", {4'd0, keyCode}, 8'h07);
        checkOutput("ovr_flag", {7'd0, overrun}, 8'd1);
        checkOutput("ovr_valid", {7'd0, keyValid}, 8'd1);
        applyStimulus(KEY_B, 1'b1, 1);
        applyStimulus(KEY_B, 1'b0, 0);
        checkOutput("ovr_ack_valid", {7'd0, keyValid}, 8'd0);
        checkOutput("ovr_ack_flag", {7'd0, overrun}, 8'd0);
        applyStimulus(16'd0, 1'b0, 0);
        waitIdle(30);

        // Acknowledge coinciding with PRESS: new key loads, no overrun.
        applyStimulus(KEY_A, 1'b0, 0);
        waitBusy(64);
        applyStimulus(KEY_A, 1'b0, 10);
        checkOutput("sim_first_valid", {7'd0, keyValid}, 8'd1);
        applyStimulus(16'd0, 1'b0, 0);
        waitIdle(30);
        applyStimulus(KEY_B, 1'b0, 0);
        waitBusy(64);
        applyStimulus(KEY_B, 1'b0, 9);
        applyStimulus(KEY_B, 1'b1, 1);
        applyStimulus(KEY_B, 1'b0, 0);
        checkOutput("sim_key", {4'd0, keyCode}, 8'h07);
        checkOutput("sim_valid", {7'd0, keyValid}, 8'd1);
        checkOutput("sim_ovr", {7'd0, overrun}, 8'd0);

        // Reset in WAIT_REL with a pending key and overrun set.
        applyStimulus(16'd0, 1'b0, 0);
        waitIdle(30);
        applyStimulus(KEY_A, 1'b0, 0);
        waitBusy(64);
        applyStimulus(KEY_A, 1'b0, 13);
        checkOutput("pre_rst_ovr", {7'd0, overrun}, 8'd1);
        checkOutput("pre_rst_busy", {7'd0, busy}, 8'd1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("arst_col", {4'd0, columnas}, 8'h0E);
        checkOutput("arst_key", {4'd0, keyCode}, 8'h00);
        checkOutput("arst_valid", {7'd0, keyValid}, 8'd0);
        checkOutput("arst_ovr", {7'd0, overrun}, 8'd0);
        checkOutput("arst_busy", {7'd0, busy}, 8'd0);
        applyStimulus(16'd0, 1'b0, 2);
        resetN = 1'b1;
        checkOutput("restart_col0", {4'd0, columnas}, 8'h0E);
        applyStimulus(16'd0, 1'b0, 4);
        checkOutput("restart_col1", {4'd0, columnas}, 8'h0D);
        checkOutput("restart_valid", {7'd0, keyValid}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
